serial_link_vc_credit_ctrl: RTL

SERIAL_LINK_VC_CREDIT_CTRL -- requirements
Module: serial_link_vc_credit_ctrl

---
 rtl/serial_link_pkg.sv | 22 ++
 rtl/serial_link_vc_credit_cnt.sv | 72 +++++++
 rtl/serial_link_vc_credit_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial link credit logic.
package serial_link_pkg;

  localparam int NumCredits      = 8;
  localparam int NumVirtChannels = 2;

  // Width of a VC index; a single-VC link still gets a 1-bit field.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // Credit count from 0 up to and including NumCredits.
  typedef logic [$clog2(NumCredits+1)-1:0] credit_t;
  typedef logic [vc_width(NumVirtChannels)-1:0] vc_id_t;

  // Credit-return handshake: IDLE picks a VC, HOLD freezes it until accepted.
  typedef enum logic {
    RetIdle = 1'b0,
    RetHold = 1'b1
  } ret_state_e;

endpackage

// File: rtl/serial_link_vc_credit_cnt.sv
// Per-VC credit bookkeeping: transmit credits available and receive
// credits pending return to the peer. Both saturate at NumCredits and
// flag an overflow pulse instead of wrapping.
module serial_link_vc_credit_cnt
  import serial_link_pkg::credit_t;
#(
  parameter int NumCredits = serial_link_pkg::NumCredits
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    flush_i,
  input  logic    tx_take_i,
  input  logic    cr_add_i,
  input  credit_t cr_num_i,
  input  logic    consume_i,
  input  logic    ret_done_i,
  output credit_t avail_o,
  output credit_t pending_o,
  output logic    ovf_o
);

  localparam int SumW = $bits(credit_t) + 1;
  typedef logic [SumW-1:0] sum_t;

  localparam sum_t    MaxSum = sum_t'(NumCredits);
  localparam credit_t MaxCr  = credit_t'(NumCredits);

  credit_t avail_q, avail_d;
  credit_t pending_q, pending_d;
  sum_t    avail_sum;
  logic    avail_ovf, pend_ovf;

  // Next-state arithmetic for both counters.
  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    avail_sum = sum_t'(avail_q)
              + (cr_add_i ? sum_t'(cr_num_i) : sum_t'(0))
              - sum_t'(tx_take_i);
    avail_ovf = (avail_sum > MaxSum);
    avail_d   = avail_ovf ? MaxCr : credit_t'(avail_sum);

    pending_d = pending_q;
    pend_ovf  = 1'b0;
    if (ret_done_i) begin
      // Everything pending went out; a same-cycle consume starts the next batch.
      pending_d = consume_i ? credit_t'(1) : credit_t'(0);
    end else if (consume_i) begin
      if (pending_q == MaxCr) pend_ovf = 1'b1;
      else                    pending_d = pending_q + credit_t'(1);
    end
  end

  // Counter registers; flush acts like reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avail_q   <= MaxCr;
      pending_q <= '0;
    end else if (flush_i) begin
      avail_q   <= MaxCr;
      pending_q <= '0;
    end else begin
      avail_q   <= avail_d;
      pending_q <= pending_d;
    end
  end

  assign avail_o   = avail_q;
  assign pending_o = pending_q;
  assign ovf_o     = avail_ovf | pend_ovf;

endmodule

// File: rtl/serial_link_vc_credit_ctrl.sv
// Virtual-channel credit controller for the serial link.
// Tracks transmit credits per VC, collects freed receive entries and
// returns them to the peer round-robin over a valid/ready channel.
// Optional: SERIAL_LINK_CREDIT_STATS_EN adds per-VC stall cycle counters.
module serial_link_vc_credit_ctrl
  import serial_link_pkg::credit_t;
  import serial_link_pkg::vc_width;
#(
  parameter int  NumVC       = 2,
  parameter int  NumCredits  = serial_link_pkg::NumCredits,
  parameter int  ForceThresh = NumCredits - 1,
  localparam int VcW         = vc_width(NumVC)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   tx_valid_i,
  input  logic [VcW-1:0]         tx_vc_i,
  output logic                   tx_ready_o,
  input  logic                   rx_cr_valid_i,
  input  logic [VcW-1:0]         rx_cr_vc_i,
  input  credit_t                rx_cr_num_i,
  input  logic [NumVC-1:0]       rx_consume_i,
  output logic                   cr_ret_valid_o,
  input  logic                   cr_ret_ready_i,
  output logic [VcW-1:0]         cr_ret_vc_o,
  output credit_t                cr_ret_num_o,
  output logic                   cr_ret_force_o,
  output credit_t [NumVC-1:0]    avail_o,
  output logic                   err_o,
  output logic [NumVC-1:0][31:0] stall_cnt_o
);

  import serial_link_pkg::ret_state_e;
  import serial_link_pkg::RetIdle;
  import serial_link_pkg::RetHold;

  logic [NumVC-1:0]    tx_take, cr_add, ret_done, ovf;
  credit_t [NumVC-1:0] avail, pending;

  ret_state_e     state_q, state_d;
  logic [VcW-1:0] hold_vc_q, rr_q, sel_vc;
  logic           any_pend, ret_hs, err_q;

  // Ready reflects the registered credit count of the addressed VC.
  always_comb begin
    tx_ready_o = 1'b0;
    for (int v = 0; v < NumVC; v++) begin
      if (tx_vc_i == VcW'(v)) tx_ready_o = (avail[v] != '0);
    end
  end

  assign ret_hs = cr_ret_valid_o & cr_ret_ready_i;

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    assign tx_take[v]  = tx_valid_i & tx_ready_o & (tx_vc_i == VcW'(v));
    assign cr_add[v]   = rx_cr_valid_i & (rx_cr_vc_i == VcW'(v));
    assign ret_done[v] = ret_hs & (cr_ret_vc_o == VcW'(v));

    serial_link_vc_credit_cnt #(
      .NumCredits (NumCredits)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .tx_take_i  (tx_take[v]),
      .cr_add_i   (cr_add[v]),
      .cr_num_i   (rx_cr_num_i),
      .consume_i  (rx_consume_i[v]),
      .ret_done_i (ret_done[v]),
      .avail_o    (avail[v]),
      .pending_o  (pending[v]),
      .ovf_o      (ovf[v])
    );
  end

  // Round-robin pick of the first VC with pending credits, starting at rr_q.
  always_comb begin
    int idx;
    sel_vc   = '0;
    any_pend = 1'b0;
    for (int i = 0; i < NumVC; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NumVC) idx = idx - NumVC;
      if (!any_pend && pending[idx] != '0) begin
        any_pend = 1'b1;
        sel_vc   = VcW'(idx);
      end
    end
  end

  // Return FSM: once offered and stalled, the VC is frozen until accepted.
  always_comb begin
    state_d        = state_q;
    cr_ret_valid_o = 1'b0;
    cr_ret_vc_o    = '0;
    case (state_q)
      RetIdle: begin
        cr_ret_valid_o = any_pend;
        cr_ret_vc_o    = sel_vc;
        if (any_pend && !cr_ret_ready_i) state_d = RetHold;
      end
      RetHold: begin
        cr_ret_valid_o = 1'b1;
        cr_ret_vc_o    = hold_vc_q;
        if (cr_ret_ready_i) state_d = RetIdle;
      end
      default: state_d = RetIdle;
    endcase
  end

  // The count only grows while held, so the offered value never shrinks.
  assign cr_ret_num_o = pending[cr_ret_vc_o];

  // Force an early return once any VC has piled up ForceThresh credits.
  always_comb begin
    cr_ret_force_o = 1'b0;
    for (int v = 0; v < NumVC; v++) begin
      if (pending[v] >= credit_t'(ForceThresh)) cr_ret_force_o = 1'b1;
    end
  end

  // FSM, held VC, round-robin pointer and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RetIdle;
      hold_vc_q <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
    end else if (flush_i) begin
      state_q   <= RetIdle;
      hold_vc_q <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RetIdle && state_d == RetHold) hold_vc_q <= sel_vc;
      if (ret_hs) begin
        rr_q <= (cr_ret_vc_o == VcW'(NumVC - 1)) ? '0 : cr_ret_vc_o + VcW'(1);
      end
      err_q <= err_q | (|ovf);
    end
  end

  assign avail_o = avail;
  assign err_o   = err_q;

`ifdef SERIAL_LINK_CREDIT_STATS_EN
  logic [NumVC-1:0][31:0] stall_q;

  // Count cycles a VC wants to send but has no credit; saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (flush_i) begin
      stall_q <= '0;
    end else begin
      for (int v = 0; v < NumVC; v++) begin
        if (tx_valid_i && !tx_ready_o && tx_vc_i == VcW'(v) && stall_q[v] != '1) begin
          stall_q[v] <= stall_q[v] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
